// File: rtl/riscv_mem_pkg.sv
// +-----------------------------------------------------------------------------+
// | riscv_mem_pkg                                                               |
// | Shared funct3 codes, byte-enable masks and MEM-stage FSM encoding.          |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    // Store funct3 shares the load encoding for the size bits (SB=LB, SH=LH, SW=LW).
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        logic half_op;
        logic word_op;
        half_op = (funct3 == F3_LH) || (funct3 == F3_LHU);
        word_op = (funct3 == F3_LW);
        return (half_op && addr[0]) || (word_op && (addr != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_align.sv
// +-----------------------------------------------------------------------------+
// | load_store_align                                                            |
// | Store byte-lane steering and load alignment with sign/zero extension.       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ext_rdata
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    always_comb begin
        be    = 4'b0000;
        wdata = rs2;
        case (funct3)
            F3_LB: begin
                be    = BE_BYTE << addr;
                wdata = {4{rs2[7:0]}};
            end
            F3_LH: begin
                be    = BE_HALF << {addr[1], 1'b0};
                wdata = {2{rs2[15:0]}};
            end
            F3_LW: begin
                be    = BE_WORD;
                wdata = rs2;
            end
            default: begin
                be    = 4'b0000;
                wdata = rs2;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign byte_shift = rdata >> {addr, 3'b000};
    assign half_shift = rdata >> {addr[1], 4'b0000};

    always_comb begin
        ext_rdata = 32'd0;
        case (funct3)
            F3_LB:   ext_rdata = {{24{byte_shift[7]}}, byte_shift[7:0]};
            F3_LH:   ext_rdata = {{16{half_shift[15]}}, half_shift[15:0]};
            F3_LW:   ext_rdata = rdata;
            F3_LBU:  ext_rdata = {24'd0, byte_shift[7:0]};
            F3_LHU:  ext_rdata = {16'd0, half_shift[15:0]};
            default: ext_rdata = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access_stage.sv
// +-----------------------------------------------------------------------------+
// | memory_access_stage                                                         |
// | RV32 MEM stage: data-memory handshake, busywait stall and MEM/WB register.  |
// | Optional MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them.|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module memory_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              reg_wb_en_ex_mem_o,
    input  logic [4:0]        rd_ex_mem_o,
    input  logic [31:0]       pc_ex_mem_o,
    input  logic [1:0]        wb_sel_ex_mem_o,
    input  logic [31:0]       imm_ex_mem_o,
    input  logic [31:0]       alu_out_ex_mem_o,
    input  logic [DATA_W-1:0] rs2_ex_mem_o,
    input  logic [2:0]        funct3_ex_mem_o,
    input  logic              is_load_instr_ex_mem_o,
    input  logic              is_store_instr_ex_mem_o,
    input  logic              is_memory_instruction_ex_mem_o,

    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ack_i,

    output logic              busywait_o,

    output logic              reg_wb_en_mem_wb_o,
    output logic [4:0]        rd_mem_wb_o,
    output logic [31:0]       pc_mem_wb_o,
    output logic [1:0]        wb_sel_mem_wb_o,
    output logic [31:0]       imm_mem_wb_o,
    output logic [31:0]       alu_out_mem_wb_o,
    output logic              is_memory_instruction_mem_wb_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_mem_wb_o,
`endif
    output logic [DATA_W-1:0] rd_data_mem_wb_o
);

    mem_state_e  state;
    mem_state_e  next_state;
    logic        mem_req;
    logic        stall;
    logic        misaligned;
    logic        access;
    logic [31:0] rdata_hold;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] ext_rdata;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (is_load_instr_ex_mem_o | is_store_instr_ex_mem_o)
                      & is_misaligned(funct3_ex_mem_o, alu_out_ex_mem_o[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign access = (is_load_instr_ex_mem_o | is_store_instr_ex_mem_o) & ~misaligned;

    load_store_align u_align (
        .funct3    (funct3_ex_mem_o),
        .addr      (alu_out_ex_mem_o[1:0]),
        .rs2       (rs2_ex_mem_o),
        .rdata     (rdata_hold),
        .be        (align_be),
        .wdata     (align_wdata),
        .ext_rdata (ext_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= MEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE drops the stall for exactly one cycle so the same instruction is never re-issued.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        stall      = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (access) begin
                    mem_req    = 1'b1;
                    stall      = 1'b1;
                    next_state = dmem_ack_i ? MEM_DONE : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (dmem_ack_i) begin
                    next_state = MEM_DONE;
                end
            end
            MEM_DONE: begin
                next_state = MEM_IDLE;
            end
            default: begin
                next_state = MEM_IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight request immediately, even with frozen memory inputs.
    assign dmem_req_o   = mem_req & ~rst_i;
    assign busywait_o   = stall & ~rst_i;
    assign dmem_we_o    = is_store_instr_ex_mem_o;
    assign dmem_addr_o  = {alu_out_ex_mem_o[ADDR_W-1:2], 2'b00};
    assign dmem_be_o    = is_load_instr_ex_mem_o ? BE_WORD : align_be;
    assign dmem_wdata_o = align_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_hold <= 32'd0;
        end else if (mem_req && dmem_ack_i) begin
            rdata_hold <= dmem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_wb_en_mem_wb_o             <= 1'b0;
            rd_mem_wb_o                    <= 5'd0;
            pc_mem_wb_o                    <= 32'd0;
            wb_sel_mem_wb_o                <= 2'd0;
            imm_mem_wb_o                   <= 32'd0;
            alu_out_mem_wb_o               <= 32'd0;
            is_memory_instruction_mem_wb_o <= 1'b0;
            rd_data_mem_wb_o               <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_mem_wb_o              <= 1'b0;
`endif
        end else if (!stall) begin
            reg_wb_en_mem_wb_o             <= reg_wb_en_ex_mem_o & ~misaligned;
            rd_mem_wb_o                    <= rd_ex_mem_o;
            pc_mem_wb_o                    <= pc_ex_mem_o;
            wb_sel_mem_wb_o                <= wb_sel_ex_mem_o;
            imm_mem_wb_o                   <= imm_ex_mem_o;
            alu_out_mem_wb_o               <= alu_out_ex_mem_o;
            is_memory_instruction_mem_wb_o <= is_memory_instruction_ex_mem_o;
            rd_data_mem_wb_o               <= (is_load_instr_ex_mem_o && !misaligned) ? ext_rdata : '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_mem_wb_o              <= misaligned;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_access_stage.sv
// +-----------------------------------------------------------------------------+
// | tb_memory_access_stage                                                      |
// | Randomized self-checking bench with a word-array memory reference model.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_memory_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        reg_wb_en_ex_mem_o;
    logic [4:0]  rd_ex_mem_o;
    logic [31:0] pc_ex_mem_o;
    logic [1:0]  wb_sel_ex_mem_o;
    logic [31:0] imm_ex_mem_o;
    logic [31:0] alu_out_ex_mem_o;
    logic [31:0] rs2_ex_mem_o;
    logic [2:0]  funct3_ex_mem_o;
    logic        is_load_instr_ex_mem_o;
    logic        is_store_instr_ex_mem_o;
    logic        is_memory_instruction_ex_mem_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        busywait_o;
    logic        reg_wb_en_mem_wb_o;
    logic [4:0]  rd_mem_wb_o;
    logic [31:0] pc_mem_wb_o;
    logic [1:0]  wb_sel_mem_wb_o;
    logic [31:0] imm_mem_wb_o;
    logic [31:0] alu_out_mem_wb_o;
    logic        is_memory_instruction_mem_wb_o;
    logic [31:0] rd_data_mem_wb_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_mem_wb_o;
`endif

    always #5 clk_i = ~clk_i;

    memory_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i                          (clk_i),
        .rst_i                          (rst_i),
        .reg_wb_en_ex_mem_o             (reg_wb_en_ex_mem_o),
        .rd_ex_mem_o                    (rd_ex_mem_o),
        .pc_ex_mem_o                    (pc_ex_mem_o),
        .wb_sel_ex_mem_o                (wb_sel_ex_mem_o),
        .imm_ex_mem_o                   (imm_ex_mem_o),
        .alu_out_ex_mem_o               (alu_out_ex_mem_o),
        .rs2_ex_mem_o                   (rs2_ex_mem_o),
        .funct3_ex_mem_o                (funct3_ex_mem_o),
        .is_load_instr_ex_mem_o         (is_load_instr_ex_mem_o),
        .is_store_instr_ex_mem_o        (is_store_instr_ex_mem_o),
        .is_memory_instruction_ex_mem_o (is_memory_instruction_ex_mem_o),
        .dmem_req_o                     (dmem_req_o),
        .dmem_we_o                      (dmem_we_o),
        .dmem_addr_o                    (dmem_addr_o),
        .dmem_be_o                      (dmem_be_o),
        .dmem_wdata_o                   (dmem_wdata_o),
        .dmem_rdata_i                   (dmem_rdata_i),
        .dmem_ack_i                     (dmem_ack_i),
        .busywait_o                     (busywait_o),
        .reg_wb_en_mem_wb_o             (reg_wb_en_mem_wb_o),
        .rd_mem_wb_o                    (rd_mem_wb_o),
        .pc_mem_wb_o                    (pc_mem_wb_o),
        .wb_sel_mem_wb_o                (wb_sel_mem_wb_o),
        .imm_mem_wb_o                   (imm_mem_wb_o),
        .alu_out_mem_wb_o               (alu_out_mem_wb_o),
        .is_memory_instruction_mem_wb_o (is_memory_instruction_mem_wb_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_mem_wb_o              (misalign_mem_wb_o),
`endif
        .rd_data_mem_wb_o               (rd_data_mem_wb_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] refmem [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Loaded value from the word and the access rules, using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] w);
        int b;
        int h;
        b = int'((w >> (8 * a)) & 32'hFF);
        h = int'((w >> (16 * (a / 2))) & 32'hFFFF);
        case (f3)
            3'b000:  return 32'(b >= 128 ? b - 256 : b);
            3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
            3'b010:  return w;
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    // kind: 0 = non-memory, 1 = load, 2 = store
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rs2, input int lat);
        int          a;
        int          idx;
        int          stalls;
        int          cnt;
        bit          seen;
        bit          mis;
        logic [31:0] word;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
        logic [3:0]  exp_be;
        logic [8:0]  exp_ctl;

        a    = int'(addr[1:0]);
        idx  = int'(addr[5:2]);
        word = refmem[idx];
        mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (kind != 0)
            mis = (((f3 == 3'b001) || (f3 == 3'b101)) && (a % 2 == 1)) || ((f3 == 3'b010) && (a != 0));
`endif

        reg_wb_en_ex_mem_o             = 1'($urandom);
        rd_ex_mem_o                    = 5'($urandom);
        pc_ex_mem_o                    = $urandom;
        wb_sel_ex_mem_o                = 2'($urandom);
        imm_ex_mem_o                   = $urandom;
        alu_out_ex_mem_o               = addr;
        rs2_ex_mem_o                   = rs2;
        funct3_ex_mem_o                = f3;
        is_load_instr_ex_mem_o         = (kind == 1);
        is_store_instr_ex_mem_o        = (kind == 2);
        is_memory_instruction_ex_mem_o = (kind != 0);

        exp_be    = 4'b0000;
        exp_wdata = rs2;
        if (kind == 1) exp_be = 4'b1111;
        else if (f3 == 3'b000) begin
            exp_be    = 4'(1 << a);
            exp_wdata = 32'(rs2 & 32'hFF) * 32'h01010101;
        end else if (f3 == 3'b001) begin
            exp_be    = 4'(3 << (2 * (a / 2)));
            exp_wdata = 32'(rs2 & 32'hFFFF) * 32'h00010001;
        end else if (f3 == 3'b010) exp_be = 4'b1111;
        exp_ld  = (kind == 1 && !mis) ? ref_load(f3, a, word) : 32'd0;
        exp_ctl = {reg_wb_en_ex_mem_o & ~mis, rd_ex_mem_o, wb_sel_ex_mem_o, is_memory_instruction_ex_mem_o};

        stalls = 0;
        cnt    = 0;
        seen   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!busywait_o) break;
            stalls++;
            if (dmem_req_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("req_we",   32'(dmem_we_o),   32'(kind == 2));
                    check("req_addr", dmem_addr_o,      {addr[31:2], 2'b00});
                    check("req_be",   32'(dmem_be_o),   32'(exp_be));
                    if (kind == 2) check("req_wdata", dmem_wdata_o, exp_wdata);
                end
                if (cnt == lat) begin
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = word;
                    if (kind == 2)
                        for (int i = 0; i < 4; i++)
                            if (exp_be[i]) refmem[idx][8*i +: 8] = exp_wdata[8*i +: 8];
                end
                cnt++;
            end
            @(posedge clk_i);
            #1;
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = $urandom;
            @(negedge clk_i);
        end
        check("stall_cycles", 32'(stalls), 32'((kind != 0 && !mis) ? lat + 1 : 0));
        check("req_after",    32'(dmem_req_o), 32'd0);
        check("req_issued",   32'(seen), 32'(kind != 0 && !mis));

        @(posedge clk_i);
        #1;
        check("wb_ctl",     32'({reg_wb_en_mem_wb_o, rd_mem_wb_o, wb_sel_mem_wb_o, is_memory_instruction_mem_wb_o}), 32'(exp_ctl));
        check("wb_pc",      pc_mem_wb_o,      pc_ex_mem_o);
        check("wb_imm",     imm_mem_wb_o,     imm_ex_mem_o);
        check("wb_alu_out", alu_out_mem_wb_o, addr);
        check("wb_rd_data", rd_data_mem_wb_o, exp_ld);
`ifdef MEM_MISALIGN_TRAP_EN
        check("wb_misalign", 32'(misalign_mem_wb_o), 32'(mis));
`endif
        @(negedge clk_i);
    endtask

    initial begin
        int          kind;
        logic [2:0]  f3;
        logic [2:0]  ld_codes [5];
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        for (int i = 0; i < 16; i++) refmem[i] = $urandom;
        rst_i                          = 1'b1;
        reg_wb_en_ex_mem_o             = 1'b0;
        rd_ex_mem_o                    = 5'd0;
        pc_ex_mem_o                    = 32'd0;
        wb_sel_ex_mem_o                = 2'd0;
        imm_ex_mem_o                   = 32'd0;
        alu_out_ex_mem_o               = 32'd0;
        rs2_ex_mem_o                   = 32'd0;
        funct3_ex_mem_o                = 3'd0;
        is_load_instr_ex_mem_o         = 1'b0;
        is_store_instr_ex_mem_o        = 1'b0;
        is_memory_instruction_ex_mem_o = 1'b0;
        dmem_rdata_i                   = 32'd0;
        dmem_ack_i                     = 1'b0;

        repeat (2) @(negedge clk_i);
        check("rst_busywait", 32'(busywait_o), 32'd0);
        check("rst_req",      32'(dmem_req_o), 32'd0);
        check("rst_wb_en",    32'(reg_wb_en_mem_wb_o), 32'd0);
        check("rst_rd_data",  rd_data_mem_wb_o, 32'd0);
        rst_i = 1'b0;

        run_instr(0, 3'b000, 32'h0000_1234, 32'h0, 0);
        run_instr(2, 3'b000, 32'h0000_0103, 32'hAABBCCDD, 2);
        refmem[0] = 32'h0080_0000;
        run_instr(1, 3'b000, 32'h0000_0102, 32'h0, 0);
        check("lb_sign",  rd_data_mem_wb_o, 32'hFFFF_FF80);
        run_instr(1, 3'b100, 32'h0000_0102, 32'h0, 0);
        check("lbu_zero", rd_data_mem_wb_o, 32'h0000_0080);
        refmem[0] = 32'h8001_0000;
        run_instr(1, 3'b001, 32'h0000_0002, 32'h0, 1);
        check("lh_sign",  rd_data_mem_wb_o, 32'hFFFF_8001);
        run_instr(1, 3'b101, 32'h0000_0002, 32'h0, 0);
        check("lhu_zero", rd_data_mem_wb_o, 32'h0000_8001);
        run_instr(1, 3'b010, 32'h0000_0100, 32'h0, 0);
        run_instr(2, 3'b010, 32'h0000_0104, 32'h1357_9BDF, 0);
        run_instr(1, 3'b010, 32'h0000_0104, 32'h0, 1);
        check("sw_then_lw", rd_data_mem_wb_o, 32'h1357_9BDF);
        run_instr(2, 3'b001, 32'h0000_0106, 32'hFFFF_5AA5, 3);
        run_instr(1, 3'b010, 32'h0000_0101, 32'h0, 0);

        // Reset while waiting for an ack.
        alu_out_ex_mem_o        = 32'h0000_0108;
        funct3_ex_mem_o         = 3'b010;
        is_load_instr_ex_mem_o  = 1'b1;
        is_store_instr_ex_mem_o = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        check("wait_req", 32'(dmem_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_req",      32'(dmem_req_o), 32'd0);
        check("rst_mid_busywait", 32'(busywait_o), 32'd0);
        check("rst_mid_alu_out",  alu_out_mem_wb_o, 32'd0);
        check("rst_mid_ctl",      32'({reg_wb_en_mem_wb_o, rd_mem_wb_o, pc_mem_wb_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_instr(1, 3'b010, 32'h0000_0108, 32'h0, 1);

        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else           f3 = ld_codes[$urandom_range(0, 4)];
            run_instr(kind, f3, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
